norm_round_stage: RTL and testbench

Normalize-and-round stage at the back end of the MAF pipeline. It takes the aligned, summed 76-bit significand and its pre-normalization exponent, then undoes the alignment with a left shift driven by a leading-zero count. It rounds round-to-nearest-even and packs IEEE results: one fp32 lane (`cont=000`) or two fp16 lanes (`cont=001`). It is a 2-register pipeline with valid/ready backpressure between the adder stage and writeback.

---
 rtl/maf_norm_pkg.sv | 45 ++++
 rtl/maf_lzc.sv | 17 +
 rtl/norm_round_stage.sv | 218 +++++++++++++++++++++
 tb/tb_norm_round_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maf_norm_pkg.sv
// Shared widths, mode encodings and packed-result types for the MAF
// normalize-and-round back end.
package maf_norm_pkg;

    localparam logic [2:0] MODE_SP = 3'b000;
    localparam logic [2:0] MODE_DH = 3'b001;

    localparam int BIAS_SP = 127;
    localparam int BIAS_HP = 15;
    localparam int EMAX_SP = 255;
    localparam int EMAX_HP = 31;

    localparam int W_SUM  = 76;
    localparam int W_LANE = 38;

    // Per-lane exponent field width in E_in for dual-half mode.
    localparam int W_EHP  = 6;

    localparam int MANT_SP = 23;
    localparam int MANT_HP = 10;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } sp_result_t;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [9:0]  mant;
    } hp_result_t;

    // Rounded lane result sized for the widest format; half lanes use the
    // low bits of exp and mant.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        ovf;
        logic        unf;
        logic        inx;
    } lane_res_t;

endpackage

// File: rtl/maf_lzc.sv
// Combinational 38-bit leading-zero counter; an all-zero input reports 38.
module maf_lzc import maf_norm_pkg::*; (
    input  logic [W_LANE-1:0] data,
    output logic [5:0]        count
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count = 6'(W_LANE);
        for (int i = 0; i < W_LANE; i++) begin
            if (data[i]) begin
                count = 6'(W_LANE - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_round_stage.sv
// Two-register normalize / round-to-nearest-even / pack stage for one fp32
// lane or two fp16 lanes, with valid/ready backpressure.
module norm_round_stage import maf_norm_pkg::*; (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cont,
    input  logic [W_SUM-1:0] M_sum,
    input  logic [11:0]      E_in,
    input  logic [1:0]       S_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [2:0]       cont_out,
    output logic [1:0]       ovf,
    output logic [1:0]       unf,
    output logic [1:0]       inx,
    output logic             invalid
);

    // Round one lane whose leading one sits at norm[75]. mant_w selects the
    // fraction width; everything below guard folds into sticky.
    function automatic lane_res_t round_lane(
        input logic [W_SUM-1:0]  norm,
        input logic [4:0]        mant_w,
        input logic signed [13:0] emax,
        input logic signed [13:0] e_pre,
        input logic              sign,
        input logic              zero
    );
        lane_res_t          r;
        logic [22:0]        mant;
        logic [23:0]        mant_inc;
        logic [W_SUM-1:0]   tail;
        logic [6:0]         g_idx;
        logic               g;
        logic               st;
        logic               rnd;
        logic signed [13:0] e;
        r        = '0;
        mant     = norm[74:52] >> (5'd23 - mant_w);
        g_idx    = 7'd74 - {2'b00, mant_w};
        g        = norm[g_idx];
        tail     = norm << ({2'b00, mant_w} + 7'd2);
        st       = |tail;
        rnd      = g & (st | mant[0]);
        mant_inc = {1'b0, mant} + {23'b0, rnd};
        e        = e_pre;
        if (mant_inc[mant_w]) begin
            mant = '0;
            e    = e_pre + 14'sd1;
        end else begin
            mant = mant_inc[22:0];
        end
        r.sign = sign;
        if (zero) begin
            r = '0;
        end else if (e >= emax) begin
            r.exp = emax[7:0];
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else if (e <= 14'sd0) begin
            r.unf = 1'b1;
            r.inx = 1'b1;
        end else begin
            r.exp  = e[7:0];
            r.mant = mant;
            r.inx  = g | st;
        end
        return r;
    endfunction

    // ---------------- handshake ----------------
    logic v1_reg;
    logic v2_reg;
    logic ready1;
    logic ready2;

    assign ready2    = !v2_reg | out_ready;
    assign ready1    = !v1_reg | ready2;
    assign in_ready  = ready1;
    assign out_valid = v2_reg;

    // ---------------- N1: leading-zero counts ----------------
    logic [1:0][5:0] lz_lane;
    logic [6:0]      lzc_sp;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lzc
            maf_lzc u_lzc (
                .data  (M_sum[gi*W_LANE +: W_LANE]),
                .count (lz_lane[gi])
            );
        end
    endgenerate

    // The low lane only matters when the whole high lane is zero.
    assign lzc_sp = (lz_lane[1] < 6'(W_LANE)) ? {1'b0, lz_lane[1]}
                                              : 7'(W_LANE) + {1'b0, lz_lane[0]};

    logic [W_SUM-1:0] m1_reg;
    logic [6:0]       lzc_sp_reg;
    logic [1:0][5:0]  lz_lane_reg;
    logic [11:0]      e1_reg;
    logic [1:0]       s1_reg;
    logic [2:0]       cont1_reg;

    // First pipeline register: capture operand plus its leading-zero counts.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_reg      <= 1'b0;
            m1_reg      <= '0;
            lzc_sp_reg  <= '0;
            lz_lane_reg <= '0;
            e1_reg      <= '0;
            s1_reg      <= '0;
            cont1_reg   <= '0;
        end else if (ready1) begin
            v1_reg      <= in_valid;
            m1_reg      <= M_sum;
            lzc_sp_reg  <= lzc_sp;
            lz_lane_reg <= lz_lane;
            e1_reg      <= E_in;
            s1_reg      <= S_in;
            cont1_reg   <= cont;
        end
    end

    // ---------------- N2: normalize, round, pack ----------------
    logic [W_SUM-1:0]   norm_sp;
    logic signed [13:0] e_sp;
    lane_res_t          sp_res;

    assign norm_sp = m1_reg << lzc_sp_reg;
    assign e_sp    = $signed({2'b00, e1_reg}) + 14'sd2 - $signed({7'b0, lzc_sp_reg});
    assign sp_res  = round_lane(norm_sp, 5'(MANT_SP), 14'(EMAX_SP), e_sp,
                                s1_reg[0], m1_reg == '0);

    logic [W_LANE-1:0] lane_norm [2];
    logic signed [7:0] e_hp      [2];
    lane_res_t         hp_res    [2];
    hp_result_t        hp_pack   [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_norm[gi] = m1_reg[gi*W_LANE +: W_LANE] << lz_lane_reg[gi];
            assign e_hp[gi]      = $signed({2'b00, e1_reg[gi*W_EHP +: W_EHP]}) + 8'sd2
                                 - $signed({2'b00, lz_lane_reg[gi]});
            assign hp_res[gi]    = round_lane({lane_norm[gi], {W_LANE{1'b0}}},
                                              5'(MANT_HP), 14'(EMAX_HP),
                                              {{6{e_hp[gi][7]}}, e_hp[gi]},
                                              s1_reg[gi],
                                              m1_reg[gi*W_LANE +: W_LANE] == '0);
            assign hp_pack[gi]   = '{sign: hp_res[gi].sign,
                                     exp:  hp_res[gi].exp[4:0],
                                     mant: hp_res[gi].mant[9:0]};
        end
    endgenerate

    sp_result_t  sp_pack;
    logic [31:0] result_next;
    logic [1:0]  ovf_next;
    logic [1:0]  unf_next;
    logic [1:0]  inx_next;
    logic        invalid_next;

    assign sp_pack = '{sign: sp_res.sign, exp: sp_res.exp, mant: sp_res.mant};

    // Select the packed result and flags for the mode of the beat in N1.
    always_comb begin
        result_next  = '0;
        ovf_next     = '0;
        unf_next     = '0;
        inx_next     = '0;
        invalid_next = 1'b0;
        case (cont1_reg)
            MODE_SP: begin
                result_next = sp_pack;
                ovf_next    = {1'b0, sp_res.ovf};
                unf_next    = {1'b0, sp_res.unf};
                inx_next    = {1'b0, sp_res.inx};
            end
            MODE_DH: begin
                result_next = {hp_pack[1], hp_pack[0]};
                ovf_next    = {hp_res[1].ovf, hp_res[0].ovf};
                unf_next    = {hp_res[1].unf, hp_res[0].unf};
                inx_next    = {hp_res[1].inx, hp_res[0].inx};
            end
            default: invalid_next = 1'b1;
        endcase
    end

    // Second pipeline register: outputs hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v2_reg   <= 1'b0;
            result   <= '0;
            cont_out <= '0;
            ovf      <= '0;
            unf      <= '0;
            inx      <= '0;
            invalid  <= 1'b0;
        end else if (ready2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                result   <= result_next;
                cont_out <= cont1_reg;
                ovf      <= ovf_next;
                unf      <= unf_next;
                inx      <= inx_next;
                invalid  <= invalid_next;
            end
        end
    end

endmodule

// File: tb/tb_norm_round_stage.sv
// Randomized and directed bench for norm_round_stage with an arithmetic
// reference model and an in-order scoreboard.
module tb_norm_round_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  cont = 3'b000;
    logic [75:0] M_sum = '0;
    logic [11:0] E_in = '0;
    logic [1:0]  S_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [2:0]  cont_out;
    logic [1:0]  ovf, unf, inx;
    logic        invalid;

    norm_round_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cont      (cont),
        .M_sum     (M_sum),
        .E_in      (E_in),
        .S_in      (S_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cont_out  (cont_out),
        .ovf       (ovf),
        .unf       (unf),
        .inx       (inx),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_drained = 0;
    logic [63:0] exp_q[$];
    logic        last_accept;
    logic        last_in_ready;
    logic        last_out_valid;
    logic [31:0] last_res;
    logic [6:0]  last_flags;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value-level reference: find the leading one, compute the exponent
    // from the bit weights, then round the fraction by comparing the
    // discarded remainder against one half ulp.
    function automatic logic [34:0] ref_lane(input logic [75:0] mag, input int lane_bits,
                                             input int e_field, input int mant_w,
                                             input int emax, input logic sign);
        int           p;
        int           e;
        int           sh;
        logic [127:0] big, q, rem, half, mant;
        logic         up, inexact;
        logic [7:0]   e8;
        logic [7:0]   emax8;
        if (mag == '0) return '0;
        p = -1;
        for (int i = 0; i < lane_bits; i++) if (mag[i]) p = i;
        e   = e_field + 2 - (lane_bits - 1 - p);
        big = 128'(mag);
        up = 1'b0;
        inexact = 1'b0;
        if (p > mant_w) begin
            sh   = p - mant_w;
            q    = big >> sh;
            rem  = big - (q << sh);
            half = 128'(1) << (sh - 1);
            up   = (rem > half) || ((rem == half) && q[0]);
            inexact = (rem != 0);
        end else begin
            q = big << (mant_w - p);
        end
        if (up) q = q + 1;
        if (q == (128'(1) << (mant_w + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        mant  = q - (128'(1) << mant_w);
        e8    = 8'(e);
        emax8 = 8'(emax);
        if (e >= emax)   return {sign, emax8, 23'b0, 3'b101};
        else if (e <= 0) return {sign, 8'b0, 23'b0, 3'b011};
        else             return {sign, e8, mant[22:0], 2'b00, inexact};
    endfunction

    // Expected observable bundle: {pad, result, cont_out, ovf, unf, inx, invalid}.
    function automatic logic [63:0] model(input logic [2:0] c, input logic [75:0] m,
                                          input logic [11:0] e, input logic [1:0] s);
        logic [34:0] l, h;
        if (c == 3'b000) begin
            l = ref_lane(m, 76, int'(e), 23, 255, s[0]);
            return {22'b0, l[34], l[33:26], l[25:3], c,
                    1'b0, l[2], 1'b0, l[1], 1'b0, l[0], 1'b0};
        end else if (c == 3'b001) begin
            h = ref_lane({38'b0, m[75:38]}, 38, int'(e[11:6]), 10, 31, s[1]);
            l = ref_lane({38'b0, m[37:0]},  38, int'(e[5:0]),  10, 31, s[0]);
            return {22'b0, h[34], h[30:26], h[12:3], l[34], l[30:26], l[12:3], c,
                    h[2], l[2], h[1], l[1], h[0], l[0], 1'b0};
        end
        return {22'b0, 32'b0, c, 6'b0, 1'b1};
    endfunction

    // One cycle: drive at the falling edge, then record what the next
    // rising edge will accept and drain.
    task automatic step(input logic iv, input logic [2:0] c, input logic [75:0] m,
                        input logic [11:0] e, input logic [1:0] s, input logic ordy);
        logic [63:0] exp_v;
        @(negedge clk);
        in_valid = iv; cont = c; M_sum = m; E_in = e; S_in = s; out_ready = ordy;
        #1;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        last_accept    = iv && in_ready;
        if (out_valid && out_ready) begin
            exp_v = (exp_q.size() == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : exp_q.pop_front();
            check_val("beat", {22'b0, result, cont_out, ovf, unf, inx, invalid}, exp_v);
            last_res   = result;
            last_flags = {ovf, unf, inx, invalid};
            n_drained++;
            $display("[TB] beat %0d cont=%b result=%h flags=%b", n_drained, cont_out, result,
                     {ovf, unf, inx, invalid});
        end
        if (last_accept) exp_q.push_back(model(c, m, e, s));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'b000, '0, '0, 2'b00, ordy);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 50) begin
            idle(1'b1);
            k++;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
        idle(1'b1);
    endtask

    task automatic run_vec(input string tag, input logic [2:0] c, input logic [75:0] m,
                           input logic [11:0] e, input logic [1:0] s,
                           input logic [31:0] exp_res, input logic [6:0] exp_flags);
        int n0;
        drain();
        n0 = n_drained;
        step(1'b1, c, m, e, s, 1'b1);
        check_val({tag, "_acc"}, 64'(last_accept), 64'd1);
        idle(1'b1);
        check_val({tag, "_lat0"}, 64'(last_out_valid), 64'd0);
        idle(1'b1);
        check_val({tag, "_lat1"}, 64'(last_out_valid), 64'd1);
        check_val({tag, "_cnt"}, 64'(n_drained - n0), 64'd1);
        check_val({tag, "_res"}, 64'(last_res), 64'(exp_res));
        check_val({tag, "_flg"}, 64'(last_flags), 64'(exp_flags));
    endtask

    task automatic rand_beat(output logic [2:0] c, output logic [75:0] m,
                             output logic [11:0] e, output logic [1:0] s);
        logic [95:0] t;
        int r;
        r = $urandom_range(0, 9);
        t = {$urandom(), $urandom(), $urandom()};
        s = 2'($urandom());
        if (r < 5) begin
            c = 3'b000;
            m = t[75:0] >> $urandom_range(0, 76);
            e = 12'($urandom_range(40, 300));
        end else if (r < 9) begin
            c = 3'b001;
            m = {t[75:38] >> $urandom_range(0, 38), t[37:0] >> $urandom_range(0, 38)};
            e = 12'($urandom());
        end else begin
            c = 3'($urandom_range(2, 7));
            m = t[75:0];
            e = 12'($urandom());
        end
    endtask

    initial begin
        logic [2:0]  rc;
        logic [75:0] rm, m_a;
        logic [11:0] re;
        logic [1:0]  rs;
        logic [63:0] held;
        int n0;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_out", {22'b0, result, cont_out, ovf, unf, inx, invalid}, 64'd0);
        check_val("rst_ready", 64'(in_ready), 64'd1);
        rstn = 1'b1;

        run_vec("sp_one",  3'b000, 76'd1 << 73, 12'd127, 2'b00, 32'h3F80_0000, 7'b00_00_00_0);
        run_vec("rne_even", 3'b000, (76'd1 << 75) | (76'd1 << 51), 12'd125, 2'b00,
                32'h3F80_0000, 7'b00_00_01_0);
        run_vec("rne_odd", 3'b000, (76'd1 << 75) | (76'd1 << 52) | (76'd1 << 51), 12'd125, 2'b00,
                32'h3F80_0002, 7'b00_00_01_0);
        m_a = ((76'd1 << 25) - 76'd1) << 51;
        run_vec("carry", 3'b000, m_a, 12'd125, 2'b00, 32'h4000_0000, 7'b00_00_01_0);
        run_vec("ovf", 3'b000, 76'd1 << 75, 12'd253, 2'b00, 32'h7F80_0000, 7'b01_00_01_0);
        run_vec("unf", 3'b000, 76'd1, 12'd10, 2'b01, 32'h8000_0000, 7'b00_01_01_0);
        run_vec("zero", 3'b000, 76'd0, 12'd100, 2'b01, 32'h0000_0000, 7'b00_00_00_0);
        run_vec("dual", 3'b001, (76'd1 << 73) | (76'd1 << 37), {6'd15, 6'd13}, 2'b10,
                32'hBC00_3C00, 7'b00_00_00_0);
        run_vec("rsvd", 3'b010, 76'd1 << 70, 12'd127, 2'b11, 32'h0000_0000, 7'b00_00_00_1);

        // Backpressure: two beats fill the pipe, the third waits.
        drain();
        n0 = n_drained;
        step(1'b1, 3'b000, 76'd1 << 73, 12'd127, 2'b00, 1'b0);
        check_val("bp_rdy0", 64'(last_in_ready), 64'd1);
        step(1'b1, 3'b000, 76'd1 << 74, 12'd127, 2'b01, 1'b0);
        check_val("bp_rdy1", 64'(last_in_ready), 64'd1);
        step(1'b1, 3'b001, (76'd1 << 75) | (76'd1 << 30), 12'd777, 2'b11, 1'b0);
        check_val("bp_full", 64'(last_in_ready), 64'd0);
        held = exp_q[0];
        step(1'b1, 3'b001, (76'd1 << 75) | (76'd1 << 30), 12'd777, 2'b11, 1'b0);
        check_val("bp_hold", {22'b0, result, cont_out, ovf, unf, inx, invalid}, held);
        check_val("bp_hold_v", 64'(out_valid), 64'd1);
        step(1'b1, 3'b001, (76'd1 << 75) | (76'd1 << 30), 12'd777, 2'b11, 1'b1);
        check_val("bp_rel", 64'(last_accept), 64'd1);
        drain();
        repeat (3) idle(1'b1);
        check_val("bp_count", 64'(n_drained - n0), 64'd3);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 400; i++) begin
            rand_beat(rc, rm, re, rs);
            step(($urandom_range(0, 3) != 0), rc, rm, re, rs, ($urandom_range(0, 9) < 7));
        end
        drain();

        // Reset with the pipe full drops everything.
        step(1'b1, 3'b001, 76'd1 << 60, 12'd500, 2'b11, 1'b0);
        step(1'b1, 3'b001, 76'd1 << 61, 12'd501, 2'b10, 1'b0);
        @(negedge clk);
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_val("mid_rst_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_out", {22'b0, result, cont_out, ovf, unf, inx, invalid}, 64'd0);
        check_val("mid_rst_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        rstn = 1'b1;
        run_vec("post_rst", 3'b000, 76'd1 << 73, 12'd128, 2'b00, 32'h4000_0000, 7'b00_00_00_0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "simulation time limit reached");
    end

endmodule
